// File: rtl/txt_pkg.sv
// Shared definitions for the text-screen RAM write controller.
// Covers command opcodes, the fill character and the controller state encoding.
package txt_pkg;

  localparam logic [1:0] OP_CHAR    = 2'b00;
  localparam logic [1:0] OP_NEWLINE = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_HOME    = 2'b11;

  localparam logic [6:0] CH_SPACE = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/txt_cursor.sv
// {row,col} raster counter with zero/newline/increment controls, wrapping at COLS/ROWS.
// Updates on the falling clock edge to match the text renderer.
module txt_cursor #(
  parameter int ROW_W = 5,
  parameter int COL_W = 6,
  parameter int ROWS  = 30,
  parameter int COLS  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zero,
  input  logic             newline,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_next;

  // No scrolling: the bottom row wraps back to the top
  assign row_next = (row == ROW_LAST) ? '0 : row + 1'b1;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (zero) begin
      row <= '0;
      col <= '0;
    end else if (newline) begin
      row <= row_next;
      col <= '0;
    end else if (inc) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row_next;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_write_ctrl.sv
// Write-side controller for the text character RAM: accepts commands, tracks the cursor
// and issues RAM writes only while the display is blanked; also runs full-screen clears.
module text_write_ctrl
  import txt_pkg::*;
#(
  parameter int ROW_W          = 5,
  parameter int COL_W          = 6,
  parameter int ROWS           = 30,
  parameter int COLS           = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                   NCLK,
  input  logic                   NRST,
  input  logic                   BLANK,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [1:0]             CMD_OP,
  input  logic [6:0]             CMD_CHAR,
  output logic                   RAM_WE,
  output logic [ROW_W+COL_W-1:0] RAM_WADDR,
  output logic [6:0]             RAM_WDATA,
  output logic [ROW_W-1:0]       CUR_ROW,
  output logic [COL_W-1:0]       CUR_COL,
  output logic                   BUSY
);

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_e                 state_q, state_d;
  logic [6:0]             char_q;
  logic                   ld_char;
  logic                   accept;
  logic                   cur_zero, cur_nl, cur_inc;
  logic                   clr_zero, clr_inc;
  logic [ROW_W-1:0]       clr_row;
  logic [COL_W-1:0]       clr_col;
  logic                   clr_last;
  logic                   wr_en;
  logic [ROW_W+COL_W-1:0] wr_addr;
  logic [6:0]             wr_data;

  assign CMD_READY = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign accept    = CMD_VALID && (state_q == ST_IDLE);
  assign clr_last  = (clr_row == ROW_LAST) && (clr_col == COL_LAST);

  txt_cursor #(.ROW_W(ROW_W), .COL_W(COL_W), .ROWS(ROWS), .COLS(COLS)) u_cursor (
    .clk     (NCLK),
    .rst_n   (NRST),
    .zero    (cur_zero),
    .newline (cur_nl),
    .inc     (cur_inc),
    .row     (CUR_ROW),
    .col     (CUR_COL)
  );

  txt_cursor #(.ROW_W(ROW_W), .COL_W(COL_W), .ROWS(ROWS), .COLS(COLS)) u_clear (
    .clk     (NCLK),
    .rst_n   (NRST),
    .zero    (clr_zero),
    .newline (1'b0),
    .inc     (clr_inc),
    .row     (clr_row),
    .col     (clr_col)
  );

  always_comb begin
    state_d  = state_q;
    ld_char  = 1'b0;
    cur_zero = 1'b0;
    cur_nl   = 1'b0;
    cur_inc  = 1'b0;
    clr_zero = 1'b0;
    clr_inc  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = {CUR_ROW, CUR_COL};
    wr_data  = char_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (CMD_OP)
            OP_CHAR: begin
              ld_char = 1'b1;
              state_d = ST_WRITE;
            end
            OP_NEWLINE: cur_nl = 1'b1;
            OP_CLEAR: begin
              clr_zero = 1'b1;
              state_d  = ST_CLEAR;
            end
            default: cur_zero = 1'b1;
          endcase
        end
      end
      // Writes wait for blanking; the display owns the RAM during active video
      ST_WRITE: begin
        if (BLANK) begin
          wr_en   = 1'b1;
          cur_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (BLANK) begin
          wr_en   = 1'b1;
          wr_addr = {clr_row, clr_col};
          wr_data = CH_SPACE;
          clr_inc = 1'b1;
          if (clr_last) begin
            cur_zero = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge NCLK or negedge NRST) begin
    if (!NRST) begin
      state_q   <= RST_STATE;
      RAM_WE    <= 1'b0;
      RAM_WADDR <= '0;
      RAM_WDATA <= '0;
    end else begin
      state_q <= state_d;
      RAM_WE  <= wr_en;
      if (wr_en) begin
        RAM_WADDR <= wr_addr;
        RAM_WDATA <= wr_data;
      end
    end
  end

  always_ff @(negedge NCLK) begin
    if (ld_char) char_q <= CMD_CHAR;
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Self-checking bench for text_write_ctrl: a scoreboard of expected RAM writes
// is filled as commands are issued and drained by a write monitor.
module tb_text_write_ctrl;

  localparam int ROW_W = 5;
  localparam int COL_W = 6;
  localparam int ROWS  = 30;
  localparam int COLS  = 64;
  localparam int CELLS = ROWS * COLS;

  logic             NCLK = 1'b0;
  logic             NRST = 1'b0;
  logic             BLANK = 1'b1;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic [1:0]       CMD_OP = 2'b00;
  logic [6:0]       CMD_CHAR = 7'h00;
  logic             RAM_WE;
  logic [10:0]      RAM_WADDR;
  logic [6:0]       RAM_WDATA;
  logic [ROW_W-1:0] CUR_ROW;
  logic [COL_W-1:0] CUR_COL;
  logic             BUSY;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [17:0] sb[$];
  int mrow = 0;
  int mcol = 0;
  bit toggling = 0;

  always #5 NCLK = ~NCLK;

  text_write_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .ROWS(ROWS), .COLS(COLS), .CLEAR_ON_RESET(1'b1)) dut (
    .NCLK(NCLK), .NRST(NRST), .BLANK(BLANK), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_CHAR(CMD_CHAR), .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR),
    .RAM_WDATA(RAM_WDATA), .CUR_ROW(CUR_ROW), .CUR_COL(CUR_COL), .BUSY(BUSY)
  );

  function automatic logic [17:0] entry(int r, int c, logic [6:0] d);
    logic [4:0] rr;
    logic [5:0] cc;
    rr = r[4:0];
    cc = c[5:0];
    return {rr, cc, d};
  endfunction

  task automatic monitor();
    logic [17:0] exp;
    forever begin
      @(posedge NCLK);
      if (RAM_WE === 1'b1) begin
        wr_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%h data=%h, none expected", RAM_WADDR, RAM_WDATA);
        end else begin
          exp = sb.pop_front();
          if ({RAM_WADDR, RAM_WDATA} !== exp) begin
            errors++;
            $display("FAIL write_content got addr=%h data=%h, expected addr=%h data=%h",
                     RAM_WADDR, RAM_WDATA, exp[17:7], exp[6:0]);
          end
        end
        checks++;
        if (BLANK !== 1'b1) begin
          errors++;
          $display("FAIL write_outside_blank got BLANK=%b, expected 1", BLANK);
        end
      end
    end
  endtask

  task automatic push_sweep();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        sb.push_back(entry(r, c, 7'h20));
  endtask

  task automatic advance_model();
    if (mcol == COLS - 1) begin
      mcol = 0;
      mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  task automatic wait_ready(input int budget, input string name);
    int k;
    for (k = 0; k < budget && CMD_READY !== 1'b1; k++) begin
      @(posedge NCLK);
      #1;
    end
    checks++;
    if (CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout got CMD_READY=%b after %0d cycles, expected 1", name, CMD_READY, budget);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [6:0] ch);
    @(posedge NCLK);
    #1;
    wait_ready(50, "send");
    CMD_VALID = 1'b1;
    CMD_OP = op;
    CMD_CHAR = ch;
    case (op)
      2'b00: begin
        sb.push_back(entry(mrow, mcol, ch));
        advance_model();
      end
      2'b01: begin
        mcol = 0;
        mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
      end
      default: begin
        mrow = 0;
        mcol = 0;
      end
    endcase
    @(posedge NCLK);
    #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic check_cursor(input string name);
    checks++;
    if (CUR_ROW !== mrow[4:0] || CUR_COL !== mcol[5:0]) begin
      errors++;
      $display("FAIL %s got cursor=(%0d,%0d), expected (%0d,%0d)", name, CUR_ROW, CUR_COL, mrow, mcol);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s got %0d pending writes, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    NRST = 1'b0;
    BLANK = 1'b1;
    repeat (3) @(posedge NCLK);
    #1;
    checks++;
    if (RAM_WE !== 1'b0 || RAM_WADDR !== 11'h000 || RAM_WDATA !== 7'h00) begin
      errors++;
      $display("FAIL reset_ram got we=%b addr=%h data=%h, expected 0/000/00", RAM_WE, RAM_WADDR, RAM_WDATA);
    end
    checks++;
    if (CMD_READY !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got ready=%b busy=%b, expected 0/1", CMD_READY, BUSY);
    end
    check_cursor("reset_cursor");
  endtask

  task automatic test_clear_on_reset();
    int base;
    base = wr_count;
    push_sweep();
    @(posedge NCLK);
    #1;
    NRST = 1'b1;
    wait_ready(CELLS + 100, "initial_clear");
    check_sb_empty("initial_clear_sb");
    checks++;
    if (wr_count - base != CELLS) begin
      errors++;
      $display("FAIL initial_clear_count got %0d writes, expected %0d", wr_count - base, CELLS);
    end
    mrow = 0;
    mcol = 0;
    check_cursor("initial_clear_cursor");
  endtask

  task automatic test_char_blank_low();
    int wc;
    BLANK = 1'b1;
    repeat (3) send_cmd(2'b01, 7'h00);
    for (int i = 0; i < 10; i++) send_cmd(2'b00, 7'(7'h61 + i));
    repeat (3) @(posedge NCLK);
    #1;
    check_cursor("setup_3_10");
    BLANK = 1'b0;
    wc = wr_count;
    send_cmd(2'b00, 7'h41);
    repeat (5) @(posedge NCLK);
    #1;
    checks++;
    if (wr_count != wc || BUSY !== 1'b1 || CMD_READY !== 1'b0) begin
      errors++;
      $display("FAIL blank_low_hold got writes=%0d busy=%b ready=%b, expected 0/1/0", wr_count - wc, BUSY, CMD_READY);
    end
    BLANK = 1'b1;
    repeat (3) @(posedge NCLK);
    #1;
    checks++;
    if (wr_count != wc + 1) begin
      errors++;
      $display("FAIL blank_high_write got %0d writes, expected 1", wr_count - wc);
    end
    check_sb_empty("blank_char_sb");
    check_cursor("cursor_3_11");
  endtask

  task automatic test_wrap();
    int wc;
    BLANK = 1'b1;
    repeat (26) send_cmd(2'b01, 7'h00);
    for (int i = 0; i < 63; i++) send_cmd(2'b00, 7'(7'h30 + (i % 10)));
    repeat (3) @(posedge NCLK);
    #1;
    check_cursor("cursor_29_63");
    send_cmd(2'b00, 7'h5A);
    repeat (3) @(posedge NCLK);
    #1;
    check_sb_empty("wrap_char_sb");
    check_cursor("wrap_cursor_0_0");
    send_cmd(2'b11, 7'h00);
    repeat (29) send_cmd(2'b01, 7'h00);
    for (int i = 0; i < 5; i++) send_cmd(2'b00, 7'(7'h42 + i));
    repeat (3) @(posedge NCLK);
    #1;
    check_cursor("cursor_29_5");
    wc = wr_count;
    send_cmd(2'b01, 7'h00);
    repeat (3) @(posedge NCLK);
    #1;
    checks++;
    if (wr_count != wc) begin
      errors++;
      $display("FAIL newline_no_write got %0d writes, expected 0", wr_count - wc);
    end
    check_cursor("newline_wrap_0_0");
  endtask

  task automatic blank_toggler();
    while (toggling) begin
      BLANK = 1'b1;
      repeat (4) begin @(posedge NCLK); #1; end
      BLANK = 1'b0;
      repeat (4) begin @(posedge NCLK); #1; end
    end
    BLANK = 1'b1;
  endtask

  task automatic test_clear_toggle();
    int base;
    BLANK = 1'b1;
    send_cmd(2'b11, 7'h00);
    base = wr_count;
    push_sweep();
    send_cmd(2'b10, 7'h00);
    toggling = 1;
    fork
      blank_toggler();
    join_none
    wait_ready(3 * CELLS, "toggle_clear");
    toggling = 0;
    repeat (10) @(posedge NCLK);
    #1;
    check_sb_empty("toggle_clear_sb");
    checks++;
    if (wr_count - base != CELLS) begin
      errors++;
      $display("FAIL toggle_clear_count got %0d writes, expected %0d", wr_count - base, CELLS);
    end
    check_cursor("toggle_clear_cursor");
  endtask

  task automatic test_reset_mid_clear();
    int base;
    int k;
    BLANK = 1'b1;
    base = wr_count;
    push_sweep();
    send_cmd(2'b10, 7'h00);
    for (k = 0; k < 1000 && wr_count != base + 7 * COLS + 21; k++) begin
      @(posedge NCLK);
      #1;
    end
    checks++;
    if (wr_count != base + 7 * COLS + 21 || RAM_WADDR !== {5'd7, 6'd20}) begin
      errors++;
      $display("FAIL mid_clear_reach got writes=%0d addr=%h, expected %0d/%h",
               wr_count - base, RAM_WADDR, 7 * COLS + 21, {5'd7, 6'd20});
    end
    NRST = 1'b0;
    #1;
    checks++;
    if (RAM_WE !== 1'b0 || RAM_WADDR !== 11'h000 || RAM_WDATA !== 7'h00 || CUR_ROW !== 5'd0 || CUR_COL !== 6'd0) begin
      errors++;
      $display("FAIL async_reset got we=%b addr=%h data=%h cursor=(%0d,%0d), expected all 0",
               RAM_WE, RAM_WADDR, RAM_WDATA, CUR_ROW, CUR_COL);
    end
    sb.delete();
    mrow = 0;
    mcol = 0;
    base = wr_count;
    repeat (3) @(posedge NCLK);
    #1;
    checks++;
    if (wr_count != base || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold got writes=%0d busy=%b, expected 0/1", wr_count - base, BUSY);
    end
    push_sweep();
    NRST = 1'b1;
    wait_ready(CELLS + 100, "restart_clear");
    check_sb_empty("restart_clear_sb");
    checks++;
    if (wr_count - base != CELLS) begin
      errors++;
      $display("FAIL restart_clear_count got %0d writes, expected %0d", wr_count - base, CELLS);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int sent;
    logic exp_ready;
    BLANK = 1'b1;
    base = wr_count;
    sent = 0;
    exp_ready = 1'b1;
    @(posedge NCLK);
    #1;
    CMD_VALID = 1'b1;
    CMD_OP = 2'b00;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      checks++;
      if (CMD_READY !== exp_ready) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d got %b, expected %b", c, CMD_READY, exp_ready);
      end
      if (CMD_READY === 1'b1) begin
        CMD_CHAR = 7'(7'h50 + sent);
        sb.push_back(entry(mrow, mcol, CMD_CHAR));
        advance_model();
        sent++;
      end
      exp_ready = ~exp_ready;
      @(posedge NCLK);
      #1;
    end
    CMD_VALID = 1'b0;
    repeat (4) @(posedge NCLK);
    #1;
    check_sb_empty("b2b_sb");
    checks++;
    if (wr_count - base != 8 || sent != 8) begin
      errors++;
      $display("FAIL b2b_count got %0d writes %0d sent, expected 8/8", wr_count - base, sent);
    end
    check_cursor("b2b_cursor_0_8");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_clear_on_reset();
    test_char_blank_low();
    test_wrap();
    test_clear_toggle();
    test_reset_mid_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
